// File: rtl/mac_result_fifo.sv
// First-word-fall-through result FIFO behind the MAC stage: captures strobed results,
// serves them over valid/ready, and drops/counts words that arrive while full.
module mac_result_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_stat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [CNT_W-1:0] count_nxt;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a word alongside a pop.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    pop       = out_valid & out_ready;
    push      = in_valid & (~full | pop);
    drop      = in_valid & full & ~pop;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  assign out_data = mem[rd_ptr];

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
    end
  end

  // Drop statistics; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf      <= 1'b1;
      drop_cnt <= clr_stat ? DROP_W'(1) : sat_inc(drop_cnt);
    end else if (clr_stat) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mac_result_fifo.sv
// Directed and randomized bench for mac_result_fifo; a second instance with DROP_W=2
// shares the stimulus to exercise drop counter saturation.
module tb_mac_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       clr_stat;

  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       ovf;
  logic [7:0] drop_cnt;

  logic       d2_out_valid;
  logic [7:0] d2_out_data;
  logic [3:0] d2_count;
  logic       d2_ovf;
  logic [1:0] d2_drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_result_fifo #(.WIDTH(8), .DEPTH(8), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .ovf(ovf), .drop_cnt(drop_cnt), .clr_stat(clr_stat)
  );

  mac_result_fifo #(.WIDTH(8), .DEPTH(8), .DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .count(d2_count), .ovf(d2_ovf), .drop_cnt(d2_drop_cnt), .clr_stat(clr_stat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_stat  = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic fill(input int base);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (out_valid !== 1'b0 || count !== 4'd0 || out_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_state: valid=%b count=%0d data=%h want 0/0/00", out_valid, count, out_data);
    end
    n_cmp++;
    // Build count=5 and a drop, then reset mid-cycle.
    fill(8'h20);
    in_valid = 1'b1; in_data = 8'h99; step(); in_valid = 1'b0;
    out_ready = 1'b1; step(); step(); step(); out_ready = 1'b0;
    if (count !== 4'd5 || out_valid !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL reset_setup: count=%0d valid=%b ovf=%b want 5/1/1", count, out_valid, ovf);
    end
    n_cmp++;
    #1 rst = 1'b1;
    #1;
    if (out_valid !== 1'b0 || count !== 4'd0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_async: valid=%b count=%0d ovf=%b drop=%0d want all 0", out_valid, count, ovf, drop_cnt);
    end
    n_cmp++;
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || count !== 4'd1) begin
      n_fail++; $display("FAIL reset_first_push: valid=%b data=%h count=%0d want 1/11/1", out_valid, out_data, count);
    end
    n_cmp++;
  endtask

  task automatic test_order();
    logic [7:0] exp [3];
    exp = '{8'd3, 8'd7, 8'd9};
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = exp[i];
      step();
    end
    in_valid = 1'b0;
    if (count !== 4'd3 || out_data !== 8'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL order_fill: count=%0d data=%0d valid=%b want 3/3/1", count, out_data, out_valid);
    end
    n_cmp++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        n_fail++; $display("FAIL order_pop%0d: valid=%b data=%0d want 1/%0d", i, out_valid, out_data, exp[i]);
      end
      n_cmp++;
      step();
    end
    out_ready = 1'b0;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL order_empty: count=%0d valid=%b want 0/0", count, out_valid);
    end
    n_cmp++;
  endtask

  task automatic test_overflow();
    do_reset();
    fill(1);
    in_valid = 1'b1; in_data = 8'hAA; step(); in_valid = 1'b0;
    if (ovf !== 1'b1 || drop_cnt !== 8'd1 || count !== 4'd8) begin
      n_fail++; $display("FAIL ovf_drop: ovf=%b drop=%0d count=%0d want 1/1/8", ovf, drop_cnt, count);
    end
    n_cmp++;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_drain%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(i));
      end
      n_cmp++;
      step();
    end
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL ovf_empty: valid=%b count=%0d want 0/0", out_valid, count);
    end
    n_cmp++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    fill(1);
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    if (count !== 4'd8 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL fullpp_count: count=%0d ovf=%b drop=%0d want 8/0/0", count, ovf, drop_cnt);
    end
    n_cmp++;
    for (int i = 2; i <= 9; i++) begin
      logic [7:0] e;
      e = (i == 9) ? 8'h55 : 8'(i);
      if (out_valid !== 1'b1 || out_data !== e) begin
        n_fail++; $display("FAIL fullpp_drain%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, e);
      end
      n_cmp++;
      step();
    end
    out_ready = 1'b0;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fullpp_empty: valid=%b want 0", out_valid);
    end
    n_cmp++;
  endtask

  task automatic test_drop_sat();
    logic [1:0] exp2 [4];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    fill(8'h40);
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      step();
      if (d2_drop_cnt !== exp2[i] || drop_cnt !== 8'(i + 1) || d2_ovf !== 1'b1) begin
        n_fail++; $display("FAIL drop_sat%0d: d2=%0d d8=%0d ovf=%b want %0d/%0d/1", i, d2_drop_cnt, drop_cnt, d2_ovf, exp2[i], i + 1);
      end
      n_cmp++;
    end
    clr_stat = 1'b1;
    step();
    if (d2_ovf !== 1'b1 || d2_drop_cnt !== 2'd1 || ovf !== 1'b1 || drop_cnt !== 8'd1) begin
      n_fail++; $display("FAIL clr_with_drop: ovf=%b/%b drop=%0d/%0d want 1/1 1/1", d2_ovf, ovf, d2_drop_cnt, drop_cnt);
    end
    n_cmp++;
    in_valid = 1'b0;
    step();
    clr_stat = 1'b0;
    if (d2_ovf !== 1'b0 || d2_drop_cnt !== 2'd0 || ovf !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL clr_alone: ovf=%b/%b drop=%0d/%0d want 0/0 0/0", d2_ovf, ovf, d2_drop_cnt, drop_cnt);
    end
    n_cmp++;
    if (count !== 4'd8 || out_data !== 8'h40) begin
      n_fail++; $display("FAIL clr_contents: count=%0d data=%h want 8/40", count, out_data);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       mpop;
    logic       mpush;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 55);
      out_ready = ($urandom_range(0, 99) < 45);
      in_data   = 8'($urandom);
      mpop  = (q.size() != 0) && out_ready;
      mpush = in_valid && ((q.size() < 8) || mpop);
      if (mpop) begin
        if (out_data !== q[0]) begin
          n_fail++; $display("FAIL rand_data@%0d: data=%h want %h", c, out_data, q[0]);
        end
        n_cmp++;
      end
      step();
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(in_data);
      if (count !== 4'(q.size()) || out_valid !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rand_count@%0d: count=%0d valid=%b want %0d", c, count, out_valid, q.size());
      end
      n_cmp++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_drop_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
